// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared state encodings and load clamp for the modular action counter
package contador_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Out-of-range load values pin to the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] modulo);
    return (value >= modulo) ? (modulo - 32'd1) : value;
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// rtl/contador_saturado.sv - saturating incrementer with synchronous clear
module contador_saturado #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/contador_modular_param.sv
// rtl/contador_modular_param.sv - modulo up/down action counter with load, power gate and one-shot mode
module contador_modular_param
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned MODULO      = 6,
  parameter int unsigned RESET_VALUE = 5,
  parameter int unsigned ONE_SHOT    = 0,
  parameter int unsigned WRAP_W      = 8
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              power,
  input  logic              enable,
  input  logic              up_down,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  output logic [WIDTH-1:0]  bits_out,
  output logic              terminal,
  output logic              done,
  output logic [WRAP_W-1:0] wraps
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VALUE);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             terminal_q, terminal_d;
  logic             done_q, done_d;
  logic             wrap_inc;
  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = WIDTH'(clamp_load(32'(load_value), 32'(MODULO)));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    terminal_d = 1'b0;
    wrap_inc   = 1'b0;
    if (reset) begin
      state_d = power ? ST_RUN : ST_OFF;
      count_d = RST_C;
    end else if (!power) begin
      state_d = ST_OFF;
      count_d = '0;
    end else begin
      case (state_q)
        // Power-up edge only changes state; counting starts on the next edge.
        ST_OFF: begin
          state_d = ST_RUN;
          count_d = '0;
        end
        ST_RUN: begin
          if (load) begin
            count_d = load_clamped;
          end else if (enable) begin
            if (up_down) begin
              if (count_q == MAX_C) begin
                if (ONE_SHOT != 0) begin
                  state_d = ST_DONE;
                end else begin
                  count_d    = '0;
                  terminal_d = 1'b1;
                  wrap_inc   = 1'b1;
                end
              end else begin
                count_d = count_q + 1'b1;
              end
            end else begin
              if (count_q == '0) begin
                if (ONE_SHOT != 0) begin
                  state_d = ST_DONE;
                end else begin
                  count_d    = MAX_C;
                  terminal_d = 1'b1;
                  wrap_inc   = 1'b1;
                end
              end else begin
                count_d = count_q - 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (load) begin
            state_d = ST_RUN;
            count_d = load_clamped;
          end
        end
        default: begin
          state_d = ST_OFF;
          count_d = '0;
        end
      endcase
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock_in) begin
    state_q    <= state_d;
    count_q    <= count_d;
    terminal_q <= terminal_d;
    done_q     <= done_d;
  end

  contador_saturado #(.W(WRAP_W)) u_wraps (
    .clk_i   (clock_in),
    .clear_i (reset),
    .inc_i   (wrap_inc),
    .count_o (wraps)
  );

  assign bits_out = count_q;
  assign terminal = terminal_q;
  assign done     = done_q;

endmodule

// File: tb/tb_contador_modular_param.sv
// tb/tb_contador_modular_param.sv - scoreboard bench for three counter configurations
module tb_contador_modular_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       pwr [3];
  logic       en  [3];
  logic       ud  [3];
  logic       ld  [3];
  logic [2:0] lv  [3];
  logic [2:0] bo  [3];
  logic       term[3];
  logic       dn  [3];
  logic [7:0] wr0, wr1;
  logic [1:0] wr2;

  contador_modular_param u_wrap (
    .clock_in(clk), .reset(rst[0]), .power(pwr[0]), .enable(en[0]), .up_down(ud[0]),
    .load(ld[0]), .load_value(lv[0]), .bits_out(bo[0]), .terminal(term[0]), .done(dn[0]), .wraps(wr0));

  contador_modular_param #(.ONE_SHOT(1)) u_oneshot (
    .clock_in(clk), .reset(rst[1]), .power(pwr[1]), .enable(en[1]), .up_down(ud[1]),
    .load(ld[1]), .load_value(lv[1]), .bits_out(bo[1]), .terminal(term[1]), .done(dn[1]), .wraps(wr1));

  contador_modular_param #(.WRAP_W(2)) u_sat (
    .clock_in(clk), .reset(rst[2]), .power(pwr[2]), .enable(en[2]), .up_down(ud[2]),
    .load(ld[2]), .load_value(lv[2]), .bits_out(bo[2]), .terminal(term[2]), .done(dn[2]), .wraps(wr2));

  typedef struct {
    int         dut;
    logic [2:0] bits;
    logic       term;
    logic       dn;
    logic [7:0] wr;
    string      name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input string field, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s.%s got %0d expected %0d", name, field, act, exp);
  endtask

  task automatic step(input int d, input logic r, input logic p, input logic e, input logic u,
                      input logic l, input logic [2:0] v, input logic [2:0] eb, input logic et,
                      input logic ed, input logic [7:0] ew, input string nm);
    exp_t x;
    @(negedge clk);
    rst[d] = r; pwr[d] = p; en[d] = e; ud[d] = u; ld[d] = l; lv[d] = v;
    x.dut = d; x.bits = eb; x.term = et; x.dn = ed; x.wr = ew; x.name = nm;
    sb.push_back(x);
  endtask

  // Monitor: every output update lands one edge after the stimulus that caused it.
  initial begin
    exp_t e;
    logic [7:0] w;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        w = (e.dut == 0) ? wr0 : (e.dut == 1) ? wr1 : {6'b0, wr2};
        chk(e.name, "bits_out", int'(bo[e.dut]), int'(e.bits));
        chk(e.name, "terminal", int'(term[e.dut]), int'(e.term));
        chk(e.name, "done", int'(dn[e.dut]), int'(e.dn));
        chk(e.name, "wraps", int'(w), int'(e.wr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; pwr[i] = 1'b1; en[i] = 1'b0; ud[i] = 1'b1; ld[i] = 1'b0; lv[i] = 3'd0;
    end

    // wrap mode, MODULO 6
    step(0, 1,1,0,1,0,3'd0, 3'd5,0,0,8'd0, "a_reset");
    step(0, 0,1,1,1,0,3'd0, 3'd0,1,0,8'd1, "a_wrap_up");
    step(0, 0,1,1,1,0,3'd0, 3'd1,0,0,8'd1, "a_up1");
    step(0, 0,1,1,1,0,3'd0, 3'd2,0,0,8'd1, "a_up2");
    step(0, 0,1,1,1,1,3'd0, 3'd0,0,0,8'd1, "a_load0");
    step(0, 0,1,1,0,0,3'd0, 3'd5,1,0,8'd2, "a_wrap_down");
    step(0, 0,1,1,0,0,3'd0, 3'd4,0,0,8'd2, "a_down");
    step(0, 0,1,1,1,1,3'd7, 3'd5,0,0,8'd2, "a_load_clamp");
    step(0, 0,1,0,1,0,3'd0, 3'd5,0,0,8'd2, "a_hold");
    step(0, 0,1,0,1,1,3'd3, 3'd3,0,0,8'd2, "a_load3");
    step(0, 0,0,1,1,0,3'd0, 3'd0,0,0,8'd2, "a_power_off");
    step(0, 0,0,1,1,0,3'd0, 3'd0,0,0,8'd2, "a_off_hold");
    step(0, 0,1,1,1,0,3'd0, 3'd0,0,0,8'd2, "a_off_to_run");
    step(0, 0,1,1,1,0,3'd0, 3'd1,0,0,8'd2, "a_first_step");
    step(0, 1,0,0,1,0,3'd0, 3'd5,0,0,8'd0, "a_reset_pwr0");
    step(0, 0,0,0,1,0,3'd0, 3'd0,0,0,8'd0, "a_off_after_rst");
    step(0, 0,1,0,1,0,3'd0, 3'd0,0,0,8'd0, "a_power_on");
    step(0, 0,1,1,1,0,3'd0, 3'd1,0,0,8'd0, "a_run_again");

    // one-shot mode
    step(1, 1,1,0,1,0,3'd0, 3'd5,0,0,8'd0, "b_reset");
    step(1, 0,1,0,1,1,3'd4, 3'd4,0,0,8'd0, "b_load4");
    step(1, 0,1,1,1,0,3'd0, 3'd5,0,0,8'd0, "b_up5");
    step(1, 0,1,1,1,0,3'd0, 3'd5,0,1,8'd0, "b_done");
    step(1, 0,1,1,1,0,3'd0, 3'd5,0,1,8'd0, "b_done_hold1");
    step(1, 0,1,1,1,0,3'd0, 3'd5,0,1,8'd0, "b_done_hold2");
    step(1, 0,1,1,1,0,3'd0, 3'd5,0,1,8'd0, "b_done_hold3");
    step(1, 0,1,1,1,1,3'd2, 3'd2,0,0,8'd0, "b_load_exit");
    step(1, 0,1,1,1,0,3'd0, 3'd3,0,0,8'd0, "b_up3");
    step(1, 0,1,0,0,1,3'd0, 3'd0,0,0,8'd0, "b_load0");
    step(1, 0,1,1,0,0,3'd0, 3'd0,0,1,8'd0, "b_done_low");
    step(1, 0,0,1,0,0,3'd0, 3'd0,0,0,8'd0, "b_done_poweroff");
    step(1, 0,1,0,1,0,3'd0, 3'd0,0,0,8'd0, "b_power_on");
    step(1, 0,1,1,1,0,3'd0, 3'd1,0,0,8'd0, "b_step");
    step(1, 0,1,0,0,1,3'd0, 3'd0,0,0,8'd0, "b_load0_again");
    step(1, 0,1,1,0,0,3'd0, 3'd0,0,1,8'd0, "b_done_again");
    step(1, 1,1,1,1,0,3'd0, 3'd5,0,0,8'd0, "b_reset_in_done");
    step(1, 0,1,1,1,0,3'd0, 3'd5,0,1,8'd0, "b_done_top");

    // wrap tally saturation at WRAP_W=2
    step(2, 1,1,0,1,0,3'd0, 3'd5,0,0,8'd0, "c_reset");
    step(2, 0,1,1,1,0,3'd0, 3'd0,1,0,8'd1, "c_wrap1");
    step(2, 0,1,1,0,0,3'd0, 3'd5,1,0,8'd2, "c_wrap2");
    step(2, 0,1,1,0,0,3'd0, 3'd4,0,0,8'd2, "c_down");
    step(2, 0,1,1,1,0,3'd0, 3'd5,0,0,8'd2, "c_up");
    step(2, 0,1,1,1,0,3'd0, 3'd0,1,0,8'd3, "c_wrap3");
    step(2, 0,1,1,0,0,3'd0, 3'd5,1,0,8'd3, "c_wrap4_sat");
    step(2, 0,1,1,0,0,3'd0, 3'd4,0,0,8'd3, "c_down2");
    step(2, 0,1,1,1,0,3'd0, 3'd5,0,0,8'd3, "c_up2");
    step(2, 0,1,1,1,0,3'd0, 3'd0,1,0,8'd3, "c_wrap5_sat");
    step(2, 1,1,0,1,0,3'd0, 3'd5,0,0,8'd0, "c_reset_clear");

    repeat (3) @(negedge clk);
    chk("drain", "queue", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
